// File: rtl/mips_pkg.sv
// mips_pkg -- shared types and constants for the MIPS core front end.
//   NOP_INSTR     : encoding presented to IF/ID when no live instruction exists
//   PC_W          : program-counter width
//   fetch_state_t : fetch FSM states (REQ issue, WAIT for data, DROP squashed data)
package mips_pkg;

    localparam int PC_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- instruction-memory request/response channel.
//   imem_req_valid / imem_req_ready / imem_req_addr : request handshake
//   imem_rsp_valid / imem_rsp_data                  : response strobe, no backpressure
// Modports: master = fetch side, slave = memory side.
interface fetch_unit_if;
    import mips_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [PC_W-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr -- fetch performance counters (only built with FETCH_PERF_EN).
//   clk, reset   : core clock, synchronous active-high reset
//   fetch_inc    : one accepted, non-squashed instruction fetch this cycle
//   bubble_inc   : IF presented a bubble to a non-stalled IF/ID this cycle
//   perf_fetches : running count of fetch_inc, wraps at 2^32
//   perf_bubbles : running count of bubble_inc, wraps at 2^32
`ifdef FETCH_PERF_EN
module fetch_perf_ctr (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_inc,
    input  logic        bubble_inc,
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_bubbles
);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetches <= '0;
            perf_bubbles <= '0;
        end else begin
            if (fetch_inc)  perf_fetches <= perf_fetches + 32'd1;
            if (bubble_inc) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/fetch_unit.sv
// fetch_unit -- IF stage of the pipelined MIPS core; producer side of IF/ID.
// Owns the PC, keeps at most one instruction-memory request outstanding and
// holds the returned word in a one-entry buffer until IF/ID takes it.
//   clk, reset       : core clock, synchronous active-high reset
//   stall            : IF/ID hold, buffer not consumed this cycle
//   redirect         : taken branch/jump, fetch resumes at redirect_pc (word aligned)
//   imem             : fetch_unit_if.master, instruction-memory channel
//   pcplus4_IF       : buffered PC + 4 (driven even when invalid)
//   instr_IF         : buffered instruction, NOP when not valid
//   valid_IF         : buffer holds a live instruction
// Optional build macro FETCH_PERF_EN adds perf_fetches / perf_bubbles outputs.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    fetch_unit_if.master     imem,
    output logic [PC_W-1:0]  pcplus4_IF,
    output logic [31:0]      instr_IF,
    output logic             valid_IF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetches,
    output logic [31:0]      perf_bubbles
`endif
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] buf_pc;
    logic [31:0]     buf_instr;
    logic            buf_valid;

    logic drain;
    logic can_issue;
    logic req_fire;
    logic rsp_take;

    // A request may only go out when the buffer will be free by the time its
    // response lands; with one outstanding request this rules out overflow.
    assign drain     = buf_valid && !stall && !redirect;
    assign can_issue = !buf_valid || drain;
    assign req_fire  = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_take  = (state == WAIT) && imem.imem_rsp_valid && !redirect;

    assign imem.imem_req_valid = (state == REQ) && can_issue;
    assign imem.imem_req_addr  = pc;

    // Redirect masks the buffer combinationally so IF/ID loads a bubble.
    assign valid_IF   = buf_valid && !redirect;
    assign instr_IF   = valid_IF ? buf_instr : NOP_INSTR;
    assign pcplus4_IF = buf_pc + 32'd4;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; later assignments in this block override earlier ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REQ;
            pc        <= RESET_PC;
            buf_valid <= 1'b0;
            buf_pc    <= '0;
            buf_instr <= '0;
        end else if (redirect) begin
            pc        <= redirect_pc & ~32'd3;
            buf_valid <= 1'b0;
            unique case (state)
                REQ:     state <= req_fire ? DROP : REQ;
                // An in-flight response either arrives now (discarded) or
                // must be swallowed later in DROP.
                WAIT,
                DROP:    state <= imem.imem_rsp_valid ? REQ : DROP;
                default: state <= REQ;
            endcase
        end else begin
            if (drain) buf_valid <= 1'b0;
            unique case (state)
                REQ: begin
                    // Responses seen here are stale (e.g. from before reset).
                    if (req_fire) state <= WAIT;
                end
                WAIT: begin
                    if (rsp_take) begin
                        buf_valid <= 1'b1;
                        buf_instr <= imem.imem_rsp_data;
                        buf_pc    <= pc;
                        pc        <= pc + 32'd4;
                        state     <= REQ;
                    end
                end
                DROP: begin
                    if (imem.imem_rsp_valid) state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_ctr u_perf (
        .clk          (clk),
        .reset        (reset),
        .fetch_inc    (rsp_take),
        .bubble_inc   (!valid_IF && !stall),
        .perf_fetches (perf_fetches),
        .perf_bubbles (perf_bubbles)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// A behavioural instruction memory answers each accepted request after a
// programmable latency; expected IF/ID outputs are queued by the directed
// sequence and compared whenever IF/ID consumes an instruction.
// Build with FETCH_PERF_EN to also check the performance counters.
module tb_fetch_unit;
    import mips_pkg::*;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pcplus4_IF;
    logic [31:0] instr_IF;
    logic        valid_IF;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetches;
    logic [31:0] perf_bubbles;
`endif

    fetch_unit_if imem ();

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem         (imem),
        .pcplus4_IF   (pcplus4_IF),
        .instr_IF     (instr_IF),
        .valid_IF     (valid_IF)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetches (perf_fetches),
        .perf_bubbles (perf_bubbles)
`endif
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    int          mem_lat;
    int          mem_cnt;
    logic [31:0] mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : (32'h2400_0000 ^ a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory: samples the handshake mid-cycle, answers mem_lat
    // cycles after acceptance with one response strobe.
    initial begin
        mem_cnt  = 0;
        mem_addr = '0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            imem.imem_rsp_valid = 1'b0;
            if (mem_cnt != 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem.imem_rsp_valid = 1'b1;
                    imem.imem_rsp_data  = mem_word(mem_addr);
                end
            end
            if (!reset && imem.imem_req_valid && imem.imem_req_ready) begin
                mem_cnt  = mem_lat;
                mem_addr = imem.imem_req_addr;
            end
        end
    end

    // Scoreboard: every instruction IF/ID takes must match the next queued entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && valid_IF && !stall) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_instr", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_instr", instr_IF, e.instr);
                    check("sb_pcplus4", pcplus4_IF, e.pc4);
                end
            end
        end
    end

    initial begin
        #5000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_lat     = 1;
        imem.imem_req_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        imem.imem_req_ready = 1'b1;
        sb_q.push_back('{32'h4, 32'h2008_0005});
        sb_q.push_back('{32'h8, mem_word(32'h4)});

        // cycle 0: reset state
        @(negedge clk);
        check("rst_req_valid", 32'(imem.imem_req_valid), 32'd1);
        check("rst_req_addr", imem.imem_req_addr, 32'h0);
        check("rst_valid_IF", 32'(valid_IF), 32'd0);
        check("rst_instr_IF", instr_IF, NOP_INSTR);
        check("rst_pcplus4", pcplus4_IF, 32'h4);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetches", perf_fetches, 32'd0);
        check("rst_perf_bubbles", perf_bubbles, 32'd0);
`endif
        next_cycle();                                  // cycle 1: WAIT
        @(negedge clk);
        check("wait_no_req", 32'(imem.imem_req_valid), 32'd0);
        next_cycle();                                  // cycle 2: first instruction
        @(negedge clk);
        check("c2_valid_IF", 32'(valid_IF), 32'd1);
        check("c2_instr_IF", instr_IF, 32'h2008_0005);
        check("c2_pcplus4", pcplus4_IF, 32'h4);
        check("c2_req_valid", 32'(imem.imem_req_valid), 32'd1);
        check("c2_req_addr", imem.imem_req_addr, 32'h4);
        next_cycle();                                  // cycle 3
        next_cycle();                                  // cycles 4..6: stall
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) next_cycle();
            @(negedge clk);
            check("stall_no_req", 32'(imem.imem_req_valid), 32'd0);
            check("stall_instr", instr_IF, mem_word(32'h4));
            check("stall_pcplus4", pcplus4_IF, 32'h8);
        end
        next_cycle();                                  // cycle 7: stall released
        stall   = 1'b0;
        mem_lat = 2;
        @(negedge clk);
        check("unstall_req_valid", 32'(imem.imem_req_valid), 32'd1);
        check("unstall_req_addr", imem.imem_req_addr, 32'h8);
        next_cycle();                                  // cycle 8: redirect in WAIT
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        check("redir_wait_valid", 32'(valid_IF), 32'd0);
        check("redir_wait_req", 32'(imem.imem_req_valid), 32'd0);
        next_cycle();                                  // cycle 9: DROP swallows rsp
        redirect = 1'b0;
        @(negedge clk);
        check("drop_req_valid", 32'(imem.imem_req_valid), 32'd0);
        check("drop_valid_IF", 32'(valid_IF), 32'd0);
        next_cycle();                                  // cycle 10: fetch target
        @(negedge clk);
        check("redir_req_valid", 32'(imem.imem_req_valid), 32'd1);
        check("redir_req_addr", imem.imem_req_addr, 32'h100);
        check("redir_valid_IF", 32'(valid_IF), 32'd0);
        next_cycle();                                  // cycle 11
        next_cycle();                                  // cycle 12
        next_cycle();                                  // cycle 13: full buffer, stalled
        stall = 1'b1;
        @(negedge clk);
        check("full_valid_IF", 32'(valid_IF), 32'd1);
        check("full_instr_IF", instr_IF, mem_word(32'h100));
        next_cycle();                                  // cycle 14: redirect + stall
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        check("rs_valid_IF", 32'(valid_IF), 32'd0);
        check("rs_instr_IF", instr_IF, NOP_INSTR);
        check("rs_pcplus4", pcplus4_IF, 32'h104);
        check("rs_req_valid", 32'(imem.imem_req_valid), 32'd0);
        next_cycle();                                  // cycles 15..18: memory not ready
        redirect = 1'b0;
        stall    = 1'b0;
        imem.imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) next_cycle();
            @(negedge clk);
            check("nrdy_req_valid", 32'(imem.imem_req_valid), 32'd1);
            check("nrdy_req_addr", imem.imem_req_addr, 32'h200);
            check("nrdy_valid_IF", 32'(valid_IF), 32'd0);
        end
        next_cycle();                                  // cycle 19: accepted
        imem.imem_req_ready = 1'b1;
        mem_lat = 1;
        sb_q.push_back('{32'h204, mem_word(32'h200)});
        next_cycle();                                  // cycle 20
        next_cycle();                                  // cycle 21: consumed, next req
        @(negedge clk);
        check("c21_req_addr", imem.imem_req_addr, 32'h204);
        next_cycle();                                  // cycle 22: redirect, rsp same cycle
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        sb_q.push_back('{32'h0, mem_word(32'hFFFF_FFFC)});
        @(negedge clk);
        check("c22_valid_IF", 32'(valid_IF), 32'd0);
        next_cycle();                                  // cycle 23
        redirect = 1'b0;
        @(negedge clk);
        check("wrap_req_valid", 32'(imem.imem_req_valid), 32'd1);
        check("wrap_req_addr", imem.imem_req_addr, 32'hFFFF_FFFC);
        check("wrap_valid_IF", 32'(valid_IF), 32'd0);
        next_cycle();                                  // cycle 24
        next_cycle();                                  // cycle 25: wrapped PC
        mem_lat = 3;
        @(negedge clk);
        check("wrap_next_addr", imem.imem_req_addr, 32'h0);
        check("wrap_pcplus4", pcplus4_IF, 32'h0);
`ifdef FETCH_PERF_EN
        check("perf_fetches", perf_fetches, 32'd5);
        check("perf_bubbles", perf_bubbles, 32'd17);
`endif
        next_cycle();                                  // cycle 26: reset mid-WAIT
        reset = 1'b1;
        imem.imem_req_ready = 1'b0;
        next_cycle();                                  // cycle 27
        reset = 1'b0;
        @(negedge clk);
        check("mrst_req_valid", 32'(imem.imem_req_valid), 32'd1);
        check("mrst_req_addr", imem.imem_req_addr, 32'h0);
        check("mrst_valid_IF", 32'(valid_IF), 32'd0);
        check("mrst_pcplus4", pcplus4_IF, 32'h4);
`ifdef FETCH_PERF_EN
        check("mrst_perf_fetches", perf_fetches, 32'd0);
        check("mrst_perf_bubbles", perf_bubbles, 32'd0);
`endif
        next_cycle();                                  // cycle 28: stale response
        next_cycle();                                  // cycle 29
        imem.imem_req_ready = 1'b1;
        mem_lat = 1;
        sb_q.push_back('{32'h4, 32'h2008_0005});
        @(negedge clk);
        check("stale_req_valid", 32'(imem.imem_req_valid), 32'd1);
        check("stale_req_addr", imem.imem_req_addr, 32'h0);
        check("stale_valid_IF", 32'(valid_IF), 32'd0);
        next_cycle();                                  // cycle 30
        next_cycle();                                  // cycle 31: refetched word
        imem.imem_req_ready = 1'b0;
        @(negedge clk);
        check("refetch_valid_IF", 32'(valid_IF), 32'd1);
        repeat (4) next_cycle();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core, the producer side of the IF/ID pipeline register. It owns the PC, issues one instruction-memory request at a time over a valid/ready handshake, and holds the returned word in a one-entry buffer. The buffer drives `pcplus4_IF`/`instr_IF` until IF/ID captures it on an edge where `stall` is low. It honours `stall` from the hazard unit and `redirect` (taken branch/jump) from ID, squashing any in-flight fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  core clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  IF/ID hold; buffer not consumed this cycle
- `redirect`  in  1  taken branch/jump; next fetch from `redirect_pc`
- `redirect_pc`  in  32  target; bits [1:0] forced to 0
- `imem_req_valid`  out  1  fetch request
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_req_addr`  out  32  word-aligned fetch address
- `imem_rsp_valid`  in  1  response strobe, exactly one per accepted request, ≥1 cycle after acceptance, no backpressure
- `imem_rsp_data`  in  32  instruction word
- `pcplus4_IF`  out  32  buffered PC + 4 to IF/ID
- `instr_IF`  out  32  buffered instruction, or NOP (32'h0) when no valid instruction
- `valid_IF`  out  1  buffer holds a live instruction

## Operation
- State: `pc` (next fetch address), FSM {REQ, WAIT, DROP}, buffer {`buf_valid`, `buf_instr`, `buf_pc`}.
- `drain` = `buf_valid && !stall && !redirect`; `can_issue` = `!buf_valid || drain`.
- REQ:
  - `imem_req_valid` = `can_issue`; `imem_req_addr` = `pc`.
  - On valid&&ready → WAIT.
  - Before acceptance, valid may drop and addr may change; memory samples only on valid&&ready.
- WAIT:
  - On `imem_rsp_valid`: `buf_valid`<=1, `buf_instr`<=data, `buf_pc`<=`pc`, `pc`<=`pc`+4 (mod 2^32), → REQ.
  - The buffer is always empty at this point: a single outstanding request plus the issue rule guarantee no overflow.
- DROP: on `imem_rsp_valid`, discard the data, → REQ.
- Drain: at an edge with `drain` true, `buf_valid`<=0 unless refilled on the same edge.
- Redirect has priority over everything:
  - `pc`<=`redirect_pc & ~3`; `buf_valid`<=0.
  - `valid_IF`=0 and `instr_IF`=NOP combinationally in the redirect cycle, so IF/ID loads a bubble.
  - In REQ: accepted that cycle → DROP, else stay REQ.
  - In WAIT: rsp same cycle → REQ (data dropped), else → DROP.
  - In DROP: stay DROP, or → REQ if rsp same cycle.
- Redirect with `stall` both high: redirect wins; buffer cleared.
- `imem_rsp_valid` while in REQ (e.g. stale after reset) is ignored.
- Outputs:
  - `valid_IF` = `buf_valid && !redirect`.
  - `instr_IF` = `valid_IF ? buf_instr : 0`.
  - `pcplus4_IF` = `buf_pc + 4`, driven even when invalid.

## Timing
- Reset values: `pc`=RESET_PC, state REQ, `buf_valid`=0, `buf_pc`=0, `buf_instr`=0.
  - Hence `instr_IF`=0, `valid_IF`=0, `pcplus4_IF`=4, `imem_req_valid`=1 in the first cycle after reset.
- Reset asserted mid-WAIT/DROP: returns to REQ next edge; any subsequent stale response is ignored.
- Latency: request accepted at cycle t, response at t+k (k≥1) → `valid_IF` high at t+k+1.
- Peak throughput: one instruction per 2 cycles with k=1 (request issues in the cycle the buffer drains).
- While `stall` is high with `buf_valid`: no new request; `instr_IF`/`pcplus4_IF` stable.

## Configuration
- `FETCH_PERF_EN` defined: extra outputs `perf_fetches` (32, accepted responses not dropped) and `perf_bubbles` (32, cycles with `valid_IF`=0 and `stall`=0). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; fetch behaviour identical.

## Structure
- `mips_pkg`: `NOP_INSTR` (32'h0), `fetch_state_t` enum {REQ, WAIT, DROP}, `PC_W`=32.
- Sub-module `fetch_perf_ctr` (the two counters), instantiated only under `FETCH_PERF_EN`.
- FSM, PC and buffer stay in `fetch_unit`.

## Test plan
- Reset, memory ready always, k=1, returns 0x20080005 @0x0 → req addr 0x0 cycle 0; `instr_IF`=0x20080005, `pcplus4_IF`=0x4 at cycle 2; next req addr 0x4 at cycle 2.
- `stall` high 3 cycles with buffer full → no `imem_req_valid`, outputs stable; request issues in the first cycle `stall`=0.
- `redirect`=1, `redirect_pc`=0x103 while in WAIT, rsp 2 cycles later → response discarded, `valid_IF`=0, next req addr 0x100.
- `redirect` coincident with `stall`=1 and buffer full → `instr_IF`=0 that cycle, buffer empty next cycle, fetch from target.
- `imem_req_ready` low 4 cycles → `imem_req_valid` held, addr unchanged, no state change; `pc`=0xFFFFFFFC wraps to 0x0 after a fetch.
- `FETCH_PERF_EN`: 10 fetches, 1 redirect-dropped → `perf_fetches`=9; reset mid-WAIT → both counters 0, req addr=RESET_PC.
